// File: rtl/seq_control_pkg.sv
// Shared encodings for the multi-cycle sequencing controller: opcodes, FSM states,
// ALU function codes and the mux select pairs it drives.
package seq_control_pkg;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_ADD  = 4'b0100;
    localparam logic [3:0] OP_INC  = 4'b0101;
    localparam logic [3:0] OP_NEG  = 4'b0110;
    localparam logic [3:0] OP_SUB  = 4'b0111;
    localparam logic [3:0] OP_J    = 4'b1000;
    localparam logic [3:0] OP_BRZ  = 4'b1001;
    localparam logic [3:0] OP_JM   = 4'b1010;
    localparam logic [3:0] OP_BRN  = 4'b1011;
    localparam logic [3:0] OP_LD   = 4'b1110;
    localparam logic [3:0] OP_SVPC = 4'b1111;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    localparam logic [2:0] ALU_PASS = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_INC  = 3'd2;
    localparam logic [2:0] ALU_NEG  = 3'd3;
    localparam logic [2:0] ALU_SUB  = 3'd4;

    // PC mux pair {a,b}
    localparam logic [1:0] SEL_PC1 = 2'b00;
    localparam logic [1:0] SEL_TGT = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;

    // Write-back mux pair {a,b}
    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_MEM  = 2'b01;
    localparam logic [1:0] WB_SVPC = 2'b10;

    function automatic logic isAluOp(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_INC) || (op == OP_NEG) || (op == OP_SUB);
    endfunction

    function automatic logic [2:0] aluCode(input logic [3:0] op);
        case (op)
            OP_ADD:  return ALU_ADD;
            OP_INC:  return ALU_INC;
            OP_NEG:  return ALU_NEG;
            OP_SUB:  return ALU_SUB;
            default: return ALU_PASS;
        endcase
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-cycle counter for memory handshakes; expired flags the cycle in which the
// TIMEOUT-th consecutive ack-less cycle is being counted.
module mem_wait_timer #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign expired = en && (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/seq_control.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer driving the datapath mux selects,
// write strobes and the memory request handshake.
module seq_control
    import seq_control_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] instr_op,
    input  logic       flag_z,
    input  logic       flag_n,
    input  logic       mem_ack,
    output logic       mem_req,
    output logic       mem_we,
    output logic       ir_we,
    output logic       pc_we,
    output logic       rf_we,
    output logic       pc_sel_a,
    output logic       pc_sel_b,
    output logic       wb_sel_a,
    output logic       wb_sel_b,
    output logic [2:0] alu_op,
    output logic       fault
);

    localparam int CNT_W = ($clog2(MEM_TIMEOUT + 1) < 4) ? 4 : $clog2(MEM_TIMEOUT + 1);

    state_t      stateQ, stateD;
    logic [3:0]  opQ;
    logic        runQ;
    logic        faultQ;
    logic        waiting, timerClr, timerEn, expired;
    logic        memReq, memWe, irWe, pcWe, rfWe;
    logic [1:0]  pcSel, wbSel;
    logic [2:0]  aluOp;

    // runQ holds everything quiet until the first edge after reset release
    assign waiting  = runQ && ((stateQ == ST_FETCH) || (stateQ == ST_MEM));
    assign timerEn  = waiting && !mem_ack;
    assign timerClr = !waiting || mem_ack;

    mem_wait_timer #(
        .TIMEOUT(MEM_TIMEOUT),
        .CNT_W  (CNT_W)
    ) uTimer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (timerClr),
        .en     (timerEn),
        .expired(expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ <= ST_FETCH;
            opQ    <= '0;
            runQ   <= 1'b0;
            faultQ <= 1'b0;
        end else begin
            runQ   <= 1'b1;
            stateQ <= stateD;
            if (runQ && stateQ == ST_DECODE) opQ <= instr_op;
            if (expired) faultQ <= 1'b1;
        end
    end

    always_comb begin
        stateD = stateQ;
        if (runQ) begin
            case (stateQ)
                ST_FETCH: begin
                    if (mem_ack)      stateD = ST_DECODE;
                    else if (expired) stateD = ST_HALT;
                end
                ST_DECODE: stateD = ST_EXEC;
                ST_EXEC: begin
                    if (isAluOp(opQ) || opQ == OP_SVPC)                  stateD = ST_WB;
                    else if (opQ == OP_LD || opQ == OP_ST || opQ == OP_JM) stateD = ST_MEM;
                    else                                                  stateD = ST_FETCH;
                end
                ST_MEM: begin
                    if (mem_ack)      stateD = (opQ == OP_LD) ? ST_WB : ST_FETCH;
                    else if (expired) stateD = ST_HALT;
                end
                ST_WB:   stateD = ST_FETCH;
                ST_HALT: stateD = ST_HALT;
                default: stateD = ST_FETCH;
            endcase
        end
    end

    // Outputs depend on state/opQ only; mem_ack reaches just ir_we and the MEM-exit pc_we
    always_comb begin
        memReq = 1'b0;
        memWe  = 1'b0;
        irWe   = 1'b0;
        pcWe   = 1'b0;
        rfWe   = 1'b0;
        pcSel  = SEL_PC1;
        wbSel  = WB_ALU;
        aluOp  = ALU_PASS;
        if (runQ) begin
            case (stateQ)
                ST_FETCH: begin
                    memReq = 1'b1;
                    irWe   = mem_ack;
                end
                ST_EXEC: begin
                    if (isAluOp(opQ)) begin
                        aluOp = aluCode(opQ);
                        wbSel = WB_ALU;
                    end else begin
                        case (opQ)
                            OP_SVPC: wbSel = WB_SVPC;
                            OP_LD, OP_ST, OP_JM: ;
                            OP_J: begin
                                pcWe  = 1'b1;
                                pcSel = SEL_TGT;
                            end
                            OP_BRZ: begin
                                pcWe  = 1'b1;
                                pcSel = flag_z ? SEL_TGT : SEL_PC1;
                            end
                            OP_BRN: begin
                                pcWe  = 1'b1;
                                pcSel = flag_n ? SEL_TGT : SEL_PC1;
                            end
                            OP_NOP: begin
                                pcWe  = 1'b1;
                                pcSel = SEL_PC1;
                            end
                            default: begin
                                pcWe  = 1'b1;
                                pcSel = SEL_PC1;
                            end
                        endcase
                    end
                end
                ST_MEM: begin
                    memReq = 1'b1;
                    memWe  = (opQ == OP_ST);
                    if (opQ == OP_LD) wbSel = WB_MEM;
                    if (opQ == OP_JM) pcSel = SEL_MEM;
                    pcWe   = mem_ack && (opQ != OP_LD);
                end
                ST_WB: begin
                    rfWe  = 1'b1;
                    pcWe  = 1'b1;
                    pcSel = SEL_PC1;
                    aluOp = aluCode(opQ);
                    if (opQ == OP_LD)        wbSel = WB_MEM;
                    else if (opQ == OP_SVPC) wbSel = WB_SVPC;
                    else                     wbSel = WB_ALU;
                end
                default: ;
            endcase
        end
    end

    assign mem_req  = memReq;
    assign mem_we   = memWe;
    assign ir_we    = irWe;
    assign pc_we    = pcWe;
    assign rf_we    = rfWe;
    assign pc_sel_a = pcSel[1];
    assign pc_sel_b = pcSel[0];
    assign wb_sel_a = wbSel[1];
    assign wb_sel_b = wbSel[0];
    assign alu_op   = aluOp;
    assign fault    = faultQ;

endmodule

// File: tb/tb_seq_control.sv
// Bench for seq_control: a per-instruction cycle plan built from the opcode rules,
// replayed against the DUT with randomized waits, flags and stray acks.
module tb_seq_control;

    localparam int TIMEOUT = 15;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] instrOp;
    logic       flagZ, flagN, memAck;
    logic       mem_req, mem_we, ir_we, pc_we, rf_we;
    logic       pc_sel_a, pc_sel_b, wb_sel_a, wb_sel_b;
    logic [2:0] alu_op;
    logic       fault;

    seq_control #(.MEM_TIMEOUT(TIMEOUT)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .instr_op(instrOp),
        .flag_z  (flagZ),
        .flag_n  (flagN),
        .mem_ack (memAck),
        .mem_req (mem_req),
        .mem_we  (mem_we),
        .ir_we   (ir_we),
        .pc_we   (pc_we),
        .rf_we   (rf_we),
        .pc_sel_a(pc_sel_a),
        .pc_sel_b(pc_sel_b),
        .wb_sel_a(wb_sel_a),
        .wb_sel_b(wb_sel_b),
        .alu_op  (alu_op),
        .fault   (fault)
    );

    always #5 clk = ~clk;

    int   errCount   = 0;
    int   checkCount = 0;
    int   cycNum     = 0;
    logic modelFault = 1'b0;

    typedef struct {
        logic [3:0] op;
        logic       ack, fz, fn;
        logic       req, we, irwe, pcwe, rfwe, flt;
        logic [1:0] pcsel, wbsel;
        logic [2:0] alu;
        logic       chkAlu;
    } cyc_t;

    cyc_t q[$];

    task automatic checkVal(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checkCount++;
        if (got !== exp) begin
            errCount++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cycNum, got, exp);
        end
    endtask

    function automatic cyc_t blank(input logic [3:0] op);
        cyc_t c;
        c.op = op;
        c.ack = 1'($urandom_range(0, 1));
        c.fz = 1'($urandom_range(0, 1));
        c.fn = 1'($urandom_range(0, 1));
        c.req = 1'b0; c.we = 1'b0; c.irwe = 1'b0; c.pcwe = 1'b0; c.rfwe = 1'b0;
        c.flt = modelFault;
        c.pcsel = 2'b00; c.wbsel = 2'b00; c.alu = 3'd0; c.chkAlu = 1'b0;
        return c;
    endfunction

    // Ack-less request cycles; 15 of them in a row mean a timeout
    task automatic planWait(input logic [3:0] op, input int waits, input logic we, output logic timedOut);
        cyc_t c;
        int n = (waits >= TIMEOUT) ? TIMEOUT : waits;
        for (int i = 0; i < n; i++) begin
            c = blank(op); c.req = 1'b1; c.we = we; c.ack = 1'b0;
            q.push_back(c);
        end
        timedOut = (waits >= TIMEOUT);
        if (timedOut) modelFault = 1'b1;
    endtask

    task automatic planInstr(input logic [3:0] op, input int fw, input int mw, output logic halted);
        cyc_t c;
        logic to;
        logic [3:0] t;
        halted = 1'b0;
        planWait(op, fw, 1'b0, to);
        if (to) begin halted = 1'b1; return; end
        c = blank(op); c.req = 1'b1; c.ack = 1'b1; c.irwe = 1'b1; q.push_back(c);
        c = blank(op); q.push_back(c);
        c = blank(op);
        if (op >= 4'd4 && op <= 4'd7) begin
            t = op - 4'd3;
            c.chkAlu = 1'b1; c.alu = t[2:0];
            q.push_back(c);
            c = blank(op); c.rfwe = 1'b1; c.pcwe = 1'b1; c.wbsel = 2'b00; q.push_back(c);
        end else if (op == 4'd15) begin
            q.push_back(c);
            c = blank(op); c.rfwe = 1'b1; c.pcwe = 1'b1; c.wbsel = 2'b10; q.push_back(c);
        end else if (op == 4'd14 || op == 4'd3 || op == 4'd10) begin
            q.push_back(c);
            planWait(op, mw, op == 4'd3, to);
            if (to) begin halted = 1'b1; return; end
            c = blank(op); c.req = 1'b1; c.we = (op == 4'd3); c.ack = 1'b1;
            if (op != 4'd14) begin
                c.pcwe = 1'b1;
                c.pcsel = (op == 4'd10) ? 2'b10 : 2'b00;
            end
            q.push_back(c);
            if (op == 4'd14) begin
                c = blank(op); c.rfwe = 1'b1; c.pcwe = 1'b1; c.wbsel = 2'b01; q.push_back(c);
            end
        end else if (op == 4'd8) begin
            c.pcwe = 1'b1; c.pcsel = 2'b01; q.push_back(c);
        end else if (op == 4'd9) begin
            c.pcwe = 1'b1; c.pcsel = {1'b0, c.fz}; q.push_back(c);
        end else if (op == 4'd11) begin
            c.pcwe = 1'b1; c.pcsel = {1'b0, c.fn}; q.push_back(c);
        end else begin
            c.pcwe = 1'b1; c.pcsel = 2'b00; q.push_back(c);
        end
    endtask

    task automatic runCycle(input cyc_t c);
        instrOp = c.op; memAck = c.ack; flagZ = c.fz; flagN = c.fn;
        @(negedge clk);
        cycNum++;
        checkVal("strobes{req,we,ir,pc,rf,fault}", 16'({mem_req, mem_we, ir_we, pc_we, rf_we, fault}),
                 16'({c.req, c.we, c.irwe, c.pcwe, c.rfwe, c.flt}));
        if (c.pcwe) begin
            if (c.pcsel[1]) checkVal("pc_sel_a", 16'(pc_sel_a), 16'(1));
            else            checkVal("pc_sel", 16'({pc_sel_a, pc_sel_b}), 16'(c.pcsel));
        end
        if (c.rfwe) begin
            if (c.wbsel[1]) checkVal("wb_sel_a", 16'(wb_sel_a), 16'(1));
            else            checkVal("wb_sel", 16'({wb_sel_a, wb_sel_b}), 16'(c.wbsel));
        end
        if (c.chkAlu) checkVal("alu_op", 16'(alu_op), 16'(c.alu));
        @(posedge clk);
        #1;
    endtask

    task automatic runQueue();
        while (q.size() > 0) runCycle(q.pop_front());
    endtask

    // Two cycles in reset, release between edges, then the idle cycle before mem_req rises
    task automatic doReset();
        rst_n = 1'b0;
        modelFault = 1'b0;
        q.delete();
        runCycle(blank(4'($urandom_range(0, 15))));
        runCycle(blank(4'($urandom_range(0, 15))));
        rst_n = 1'b1;
        runCycle(blank(4'($urandom_range(0, 15))));
    endtask

    task automatic runInstr(input logic [3:0] op, input int fw, input int mw, input int haltCycles);
        logic halted;
        planInstr(op, fw, mw, halted);
        if (halted) begin
            for (int i = 0; i < haltCycles; i++) q.push_back(blank(4'($urandom_range(0, 15))));
        end
        runQueue();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; instrOp = 4'd0; memAck = 1'b0; flagZ = 1'b0; flagN = 1'b0;
        @(posedge clk);
        #1;
        doReset();

        runInstr(4'd4, 0, 0, 0);
        planInstr(4'd9, 0, 0, modelFault);
        q[2].fz = 1'b1; q[2].pcsel = 2'b01;
        runQueue();
        planInstr(4'd9, 0, 0, modelFault);
        q[2].fz = 1'b0; q[2].pcsel = 2'b00;
        runQueue();
        runInstr(4'd14, 0, 3, 0);
        runInstr(4'd10, 1, 2, 0);
        runInstr(4'd3, 0, 1, 0);
        runInstr(4'd15, 2, 0, 0);
        runInstr(4'd0, 14, 0, 0);
        runInstr(4'd14, 0, 14, 0);

        for (int i = 0; i < 60; i++) begin
            int fw, mw;
            fw = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 14)) : int'($urandom_range(0, 2));
            mw = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 14)) : int'($urandom_range(0, 2));
            runInstr(4'($urandom_range(0, 15)), fw, mw, 0);
        end

        runInstr(4'd5, 15, 0, 4);
        doReset();
        runInstr(4'd6, 0, 0, 0);
        runInstr(4'd10, 0, 15, 3);
        doReset();

        begin
            logic halted;
            planInstr(4'd14, 0, 6, halted);
            for (int i = 0; i < 5; i++) runCycle(q.pop_front());
            memAck = 1'b0;
            #1;
            checkVal("mem_req before reset", 16'(mem_req), 16'(1));
            #1 rst_n = 1'b0;
            #1;
            checkVal("outputs during async reset",
                     16'({mem_req, mem_we, ir_we, pc_we, rf_we, pc_sel_a, pc_sel_b,
                          wb_sel_a, wb_sel_b, alu_op, fault}), 16'(0));
            q.delete();
            @(posedge clk);
            #1;
            doReset();
        end
        runInstr(4'd7, 1, 0, 0);
        runInstr(4'd11, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule

// File: doc/seq_control.md
# seq_control

Multi-cycle sequencing controller for the 32-bit datapath. It walks each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the two-bit select pairs of the datapath's 3:1 muxes (PC source and register write-back source). It also drives the register, PC and IR write enables and the memory request handshake. It sits between the instruction register/flag outputs and the datapath, and is the only block that changes mux selects.

## Interface
- `MEM_TIMEOUT`, default 15: maximum cycles a memory request may wait for `mem_ack` before fault.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `instr_op`  in  4  opcode field of the instruction register.
- `flag_z`, `flag_n`  in  1 each  ALU zero/negative flags, valid in EXEC.
- `mem_ack`  in  1  memory completion; ignored unless `mem_req`=1.
- `mem_req`  out  1  memory request, held until acked.
- `mem_we`  out  1  write qualifier for `mem_req`.
- `ir_we`, `pc_we`, `rf_we`  out  1 each  single-cycle write strobes.
- `pc_sel_a`, `pc_sel_b`  out  1 each  PC mux select.
  - a=0,b=0: PC+1.
  - a=0,b=1: branch/jump target register.
  - a=1: memory data.
- `wb_sel_a`, `wb_sel_b`  out  1 each  write-back mux select.
  - 00: ALU result.
  - 01: memory data.
  - 1x: PC+imm (SVPC).
- `alu_op`  out  3  ALU function: 0 pass, 1 add, 2 inc, 3 neg, 4 sub.
- `fault`  out  1  sticky memory-timeout indicator.

## Operation
- Opcodes:
  - NOP 0000, ST 0011, ADD 0100, INC 0101, NEG 0110, SUB 0111.
  - J 1000, BRZ 1001, JM 1010, BRN 1011.
  - LD 1110, SVPC 1111.
  - All other values execute as NOP.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH: `mem_req`=1, `mem_we`=0. On `mem_ack`, pulse `ir_we` in the same cycle and go to DECODE.
- DECODE: latch `instr_op` into `op_q`, go to EXEC.
- EXEC, by `op_q`:
  - ALU ops: `alu_op` per op → WB, `wb_sel`=00.
  - SVPC → WB, `wb_sel`=10.
  - LD/ST/JM → MEM.
  - J → `pc_we`=1, sel 01, then FETCH.
  - BRZ/BRN: `pc_we`=1; sel 01 if `flag_z`/`flag_n` is 1, else 00; then FETCH.
  - NOP → `pc_we`=1, sel 00, then FETCH.
- MEM: `mem_req`=1, `mem_we`=(op_q==ST). On `mem_ack`:
  - LD → WB, `wb_sel`=01.
  - ST → `pc_we`, sel 00, then FETCH.
  - JM → `pc_we`, sel 1x, then FETCH.
- WB: `rf_we`=1, `pc_we`=1, sel 00, then FETCH.
- Timeout:
  - A 4-bit-or-wider wait counter clears on entry to FETCH/MEM and counts each cycle without ack.
  - When the counter reaches `MEM_TIMEOUT` with no ack, set `fault` and go to HALT.
- HALT: all strobes 0. Leave only by reset.
- Outputs are decoded from state register and `op_q`. No combinational path from `mem_ack` except `ir_we` and the MEM-exit `pc_we`.

## Timing
- Reset (async assert, sync release):
  - state=FETCH, `op_q`=0, counter=0, `fault`=0.
  - All outputs 0 while `rst_n`=0.
  - `mem_req` rises on the first clock edge after release.
- Zero-wait memory (ack in the request cycle) is legal.
- Minimum latencies with zero-wait memory:
  - NOP/J/BR: 3 cycles.
  - ADD/SVPC: 4 cycles.
  - ST/JM: 4 cycles.
  - LD: 5 cycles.
- Each wait cycle adds 1 cycle.
- Strobes are exactly one cycle wide. `pc_we` is asserted exactly once per instruction.
- Select outputs are stable for the whole cycle in which the corresponding write enable is 1.
- `mem_ack` in the same cycle the timeout is reached: the ack wins, no fault.
- Reset asserted mid-instruction: outputs drop to 0 immediately. The instruction is abandoned and restarts from FETCH.

## Structure
- `seq_control_pkg` holds:
  - Opcode localparams.
  - State enum encoding.
  - `alu_op` codes.
  - Select-pair constants (SEL_PC1, SEL_TGT, SEL_MEM).
- Optional sub-module `mem_wait_timer` (counter + compare, `clr`/`en`/`expired`). Everything else lives in one FSM module.

## Test plan
- Reset, then ADD with zero-wait ack → `ir_we` in cycle 1, `alu_op`=1 in EXEC; cycle 4: `rf_we`=1, `pc_we`=1, `wb_sel`=00, `pc_sel`=00.
- BRZ with `flag_z`=1, then BRZ with `flag_z`=0 → `pc_sel`=01 then 00; `pc_we` in cycle 3 each time.
- LD with 3 wait cycles in MEM → `mem_req` held 4 cycles, `mem_we`=0; WB `wb_sel`=01; total 8 cycles.
- JM → MEM ack, then `pc_sel_a`=1 with `pc_we`=1. ST → `mem_we`=1 in MEM, `rf_we` never asserted.
- `MEM_TIMEOUT`=15, no ack in FETCH → `fault`=1 after 15 cycles, HALT with all strobes 0. Ack exactly on cycle 15 → no fault.
- `rst_n` pulsed low during MEM of LD → outputs 0 asynchronously; after release, FETCH with `fault`=0.
